arb8_ctrl: RTL and testbench

Eight-way arbiter and grant sequencer for a shared resource, built around the team's 8-to-3 priority encoder. It samples eight request lines and selects one owner by fixed priority (highest index wins) or round-robin. It holds the grant until the owner releases, drops its request or exceeds a hold limit, then inserts a one-cycle idle gap before the next grant. It sits between the requesting blocks and the resource's select mux, driving a one-hot grant and a 3-bit owner index.

---
 rtl/arb8_pkg.sv | 28 ++
 rtl/arb8_ctrl_prio_enc8.sv | 28 ++
 rtl/arb8_ctrl.sv | 149 ++++++++++++++
 tb/tb_arb8_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb8_pkg.sv
// ---------------------------------------------------------------------------
// arb8_pkg
// Shared types and constants for the eight-way arbiter.
//   state_t      : arbiter FSM state (IDLE, BUSY)
//   N_REQ, ID_W  : number of requesters and owner-index width
//   rotate_right : circular right rotation of a request vector
// ---------------------------------------------------------------------------
package arb8_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Result bit j takes input bit (j + sh) mod N_REQ.
    function automatic logic [N_REQ-1:0] rotate_right(
        input logic [N_REQ-1:0] v,
        input logic [ID_W-1:0]  sh
    );
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} >> sh;
        return dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/arb8_ctrl_prio_enc8.sv
// ---------------------------------------------------------------------------
// prio_enc8
// Combinational 8-to-3 priority encoder; the highest set index wins.
// Ports:
//   din   in  8  input vector
//   idx   out 3  index of the highest set bit (0 when din is 0)
//   valid out 1  din has at least one bit set
// ---------------------------------------------------------------------------
module prio_enc8
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] din,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |din;
        // Ascending scan: later (higher) hits overwrite lower ones.
        for (int i = 0; i < N_REQ; i++) begin
            if (din[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/arb8_ctrl.sv
// ---------------------------------------------------------------------------
// arb8_ctrl
// Eight-way arbiter and grant sequencer for a shared resource.
// Picks one owner among eight requesters by fixed priority (highest index)
// or round-robin (previous owner lowest), holds the grant until release,
// then forces at least one idle cycle before the next grant.
//
// Handshake: a requester holds req[i] high while it wants the resource.
// A grant is signalled by gnt[i]/gnt_id/gnt_valid from the cycle after the
// request is sampled in IDLE. The owner keeps ownership while req[i] stays
// high; it gives the resource back with a one-cycle done pulse or by dropping
// req[i]. The arbiter revokes the grant itself after MAX_HOLD cycles and
// flags that with a one-cycle timeout pulse on the clearing edge.
//
// Parameters:
//   MAX_HOLD  maximum BUSY cycles per grant, legal range 2..256
// Ports:
//   clk       in  1  rising-edge clock
//   rst_n     in  1  asynchronous active-low reset
//   en        in  1  block enable; low forces IDLE and zero grant outputs
//   mode      in  1  0 = fixed priority, 1 = round-robin (sampled in IDLE)
//   req       in  8  request lines
//   done      in  1  release pulse from the current owner (BUSY only)
//   gnt       out 8  one-hot grant, registered
//   gnt_id    out 3  owner index, registered; 0 when no grant
//   gnt_valid out 1  grant active (equals |gnt)
//   timeout   out 1  pulse when the hold limit alone revoked the grant
// ---------------------------------------------------------------------------
module arb8_ctrl
    import arb8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    // Release happens at MAX_HOLD-1, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [ID_W-1:0]    gnt_id_d;
    logic               gnt_valid_d;
    logic               timeout_d;

    logic [N_REQ-1:0]   enc_in;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_valid;
    logic [ID_W-1:0]    win;
    logic               owner_req;
    logic               at_limit;

    // Round-robin: rotate so index last-1 sits at bit 7; the encoder then
    // scans last-1, last-2, ..., last. Adding last back (mod 8) undoes it.
    assign enc_in = mode ? rotate_right(req, last_q) : req;

    prio_enc8 u_enc (
        .din   (enc_in),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign win       = mode ? (enc_idx + last_q) : enc_idx;
    assign owner_req = req[gnt_id];
    assign at_limit  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt;
        gnt_id_d    = gnt_id;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
                if (en && enc_valid) begin
                    state_d     = BUSY;
                    gnt_d       = ONE_HOT0 << win;
                    gnt_id_d    = win;
                    gnt_valid_d = 1'b1;
                    last_d      = win;
                end
            end

            BUSY: begin
                if (!en || done || !owner_req || at_limit) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                    // Disable, done and a dropped request all outrank the
                    // hold limit; only a pure limit release is a timeout.
                    timeout_d   = en && at_limit && !done && owner_req;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_arb8_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arb8_ctrl
// Directed scenarios push one expected record per grant
// {gnt, gnt_id, length in cycles, timeout on clear} into exp_q; a monitor on
// the falling edge tracks each grant and pops/compares when it ends.
// ---------------------------------------------------------------------------
module tb_arb8_ctrl;

    localparam int MAX_HOLD = 4;
    localparam int EW = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    arb8_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [7:0] g, input logic [2:0] id,
                                         input int len, input logic to);
        return {g, id, 8'(len), to};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Grant requested with mode m / request r, held for 'hold' visible
    // cycles and ended by done; request withdrawn afterwards.
    task automatic grant_done(input logic m, input logic [7:0] r, input int hold,
                              input logic [7:0] eg, input logic [2:0] eid);
        step();
        mode = m;
        req  = r;
        exp_q.push_back(mk(eg, eid, hold, 1'b0));
        repeat (hold) step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic       prev_v = 1'b0;
    logic [7:0] cur_gnt = '0;
    logic [2:0] cur_id = '0;
    logic [7:0] cur_len = '0;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        chk("valid_vs_gnt", {31'b0, gnt_valid}, {31'b0, |gnt});
        if (gnt_valid) begin
            if (!prev_v) begin
                cur_gnt = gnt;
                cur_id  = gnt_id;
                cur_len = 8'd0;
            end
            cur_len = cur_len + 8'd1;
            chk("hold_stable", {20'b0, gnt, gnt_id, timeout}, {20'b0, cur_gnt, cur_id, 1'b0});
            chk("onehot_id", {24'b0, gnt}, {24'b0, 8'd1 << gnt_id});
        end else if (prev_v) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", {12'b0, cur_gnt, cur_id, cur_len, timeout}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("grant_record", {12'b0, cur_gnt, cur_id, cur_len, timeout}, {12'b0, e});
            end
            chk("clear_outputs", {21'b0, gnt, gnt_id}, 32'd0);
        end else begin
            chk("idle_outputs", {20'b0, gnt, gnt_id, timeout}, 32'd0);
        end
        prev_v = gnt_valid;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1;
        en    = 1'b1;
        mode  = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt",       {24'b0, gnt},       32'd0);
        chk("rst_gnt_id",    {29'b0, gnt_id},    32'd0);
        chk("rst_gnt_valid", {31'b0, gnt_valid}, 32'd0);
        chk("rst_timeout",   {31'b0, timeout},   32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Fixed priority: 8'b0010_0100 -> requester 5; done after 2 cycles,
        // one idle cycle, regrant 5, then request dropped after 1 cycle.
        step();
        mode = 1'b0;
        req  = 8'h24;
        exp_q.push_back(mk(8'h20, 3'd5, 2, 1'b0));
        exp_q.push_back(mk(8'h20, 3'd5, 1, 1'b0));
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        req = 8'h00;
        step();

        // Reset while BUSY: outputs clear without waiting for a clock.
        step();
        req = 8'h40;
        exp_q.push_back(mk(8'h40, 3'd6, 1, 1'b0));
        step();
        #2;
        rst_n = 1'b0;
        req   = 8'h00;
        #1;
        chk("async_rst_gnt",       {24'b0, gnt},       32'd0);
        chk("async_rst_gnt_valid", {31'b0, gnt_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        grant_done(1'b1, 8'h01, 1, 8'h01, 3'd0);
        grant_done(1'b1, 8'h81, 1, 8'h80, 3'd7);

        // Round-robin from a fresh reset: 7,6,5,4,3,2,1,0,7.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        mode = 1'b1;
        req  = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            logic [2:0] id;
            id = 3'(7 - i);
            exp_q.push_back(mk(8'd1 << id, id, 1, 1'b0));
        end
        for (int i = 0; i < 9; i++) begin
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            if (i == 8) begin
                req  = 8'h00;
                mode = 1'b0;
            end
        end

        // Hold limit: 4 cycles, timeout on the clear, regrant after one idle.
        step();
        req = 8'h08;
        exp_q.push_back(mk(8'h08, 3'd3, 4, 1'b1));
        exp_q.push_back(mk(8'h08, 3'd3, 1, 1'b0));
        repeat (5) step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;

        // done on the limit cycle: no timeout.
        grant_done(1'b0, 8'h02, 4, 8'h02, 3'd1);

        // Request dropped on the limit cycle: no timeout.
        step();
        req = 8'h04;
        exp_q.push_back(mk(8'h04, 3'd2, 4, 1'b0));
        repeat (4) step();
        req = 8'h00;
        step();

        // en low on the limit cycle: clear, no timeout; regrant once enabled.
        step();
        req = 8'h10;
        exp_q.push_back(mk(8'h10, 3'd4, 4, 1'b0));
        exp_q.push_back(mk(8'h10, 3'd4, 1, 1'b0));
        repeat (4) step();
        en = 1'b0;
        step();
        step();
        en = 1'b1;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;

        // Owner drops its request; pending lower requester 1 follows.
        step();
        req = 8'h22;
        exp_q.push_back(mk(8'h20, 3'd5, 2, 1'b0));
        exp_q.push_back(mk(8'h02, 3'd1, 1, 1'b0));
        step();
        step();
        req = 8'h02;
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;

        // done while IDLE must not start or disturb anything.
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        step();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
